// File: rtl/input_sampler_pkg.sv
// Shared definitions for the intercept capture path (input sampler and output buffer).
package input_sampler_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } cap_state_e;

endpackage : input_sampler_pkg

// File: rtl/input_sampler_bus_synchronizer.sv
// Per-bit multi-flop synchroniser for a bus arriving asynchronously to clk.
module bus_synchronizer #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= '0;
          else       stage_q[gi] <= d_i;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= '0;
          else       stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = stage_q[STAGES-1];

endmodule : bus_synchronizer

// File: rtl/input_sampler.sv
// Synchronises the intercepted input bus, takes debounced snapshots on request
// and serves single-bit reads of the snapshot or its change mask.
module input_sampler
  import input_sampler_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              en_capture,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] snap,
  output logic [DATA_W-1:0] changed_mask,
  output logic              rd_val,
  output logic              rd_valid,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_timeout
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] sync_data;
  logic [DATA_W-1:0] sync_prev_q;

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              rd_val_q, rd_valid_q;

  bus_synchronizer #(
    .WIDTH  (DATA_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (in_data),
    .q_o   (sync_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_prev_q <= '0;
    else       sync_prev_q <= sync_data;
  end

  // Stability count restarts whenever the synchronised bus moves.
  assign cnt_inc = (sync_data == sync_prev_q) ? cnt_q + CNT_W'(1) : '0;
  assign tmo_inc = tmo_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    snap_d    = snap_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_capture) begin
          state_d = WAIT;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        tmo_d = tmo_inc;
        // Commit takes priority over a timeout landing on the same edge.
        if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
          mask_d  = snap_q ^ sync_data;
          snap_d  = sync_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      snap_q    <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      snap_q    <= snap_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Reads see the registers as they were before this edge's commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_val_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_val_q <= rd_sel ? mask_q[addr] : snap_q[addr];
    end
  end

  assign snap         = snap_q;
  assign changed_mask = mask_q;
  assign rd_val       = rd_val_q;
  assign rd_valid     = rd_valid_q;
  assign cap_busy     = (state_q == WAIT);
  assign cap_done     = done_q;
  assign cap_timeout  = timeout_q;

endmodule : input_sampler

// File: tb/tb_input_sampler.sv
// Directed bench for input_sampler: reset, capture, change mask, timeout, debounce, coincident events.
module tb_input_sampler;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        en_capture;
  logic [4:0]  addr;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] snap;
  logic [31:0] changed_mask;
  logic        rd_val;
  logic        rd_valid;
  logic        cap_busy;
  logic        cap_done;
  logic        cap_timeout;

  int checks = 0;
  int errors = 0;

  input_sampler #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .TIMEOUT       (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .en_capture   (en_capture),
    .addr         (addr),
    .rd_en        (rd_en),
    .rd_sel       (rd_sel),
    .snap         (snap),
    .changed_mask (changed_mask),
    .rd_val       (rd_val),
    .rd_valid     (rd_valid),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .cap_timeout  (cap_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    in_data    = 32'hFFFF_FFFF;
    en_capture = 1'b0;
    addr       = '0;
    rd_en      = 1'b0;
    rd_sel     = 1'b0;
    tick();
    tick();
    check("rst_snap", snap, 32'h0);
    check("rst_mask", changed_mask, 32'h0);
    check("rst_rd_val", {31'b0, rd_val}, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_busy", {31'b0, cap_busy}, 32'h0);
    check("rst_done", {31'b0, cap_done}, 32'h0);
    check("rst_timeout", {31'b0, cap_timeout}, 32'h0);
    reset = 1'b0;

    // Test 1: reset in the middle of WAIT
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    check("t1_busy_after_e0", {31'b0, cap_busy}, 32'h1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t1_async_busy", {31'b0, cap_busy}, 32'h0);
    check("t1_async_snap", snap, 32'h0);
    check("t1_async_done", {31'b0, cap_done}, 32'h0);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cap_done || cap_timeout || cap_busy) seen = 1'b1;
    end
    check("t1_no_late_event", {31'b0, seen}, 32'h0);
    check("t1_snap_kept", snap, 32'h0);
    in_data = 32'h0;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    repeat (3) tick();
    check("t1_done_early", {31'b0, cap_done}, 32'h0);
    tick();
    check("t1_done", {31'b0, cap_done}, 32'h1);
    check("t1_snap", snap, 32'h0);

    // Test 2: steady capture, latency and busy width
    in_data = 32'hA5A5_0F0F;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    check("t2_busy_e0", {31'b0, cap_busy}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t2_busy_mid", {31'b0, cap_busy}, 32'h1);
      check("t2_done_mid", {31'b0, cap_done}, 32'h0);
    end
    tick();
    check("t2_done", {31'b0, cap_done}, 32'h1);
    check("t2_busy_end", {31'b0, cap_busy}, 32'h0);
    check("t2_snap", snap, 32'hA5A5_0F0F);
    check("t2_mask", changed_mask, 32'hA5A5_0F0F);
    tick();
    check("t2_done_pulse", {31'b0, cap_done}, 32'h0);

    // Test 3: change mask and reads
    in_data = 32'hA5A5_0F0E;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    repeat (4) tick();
    check("t3_done", {31'b0, cap_done}, 32'h1);
    check("t3_snap", snap, 32'hA5A5_0F0E);
    check("t3_mask", changed_mask, 32'h0000_0001);
    rd_sel = 1'b1;
    addr   = 5'd0;
    rd_en  = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_rd_val_a0", {31'b0, rd_val}, 32'h1);
    check("t3_rd_valid", {31'b0, rd_valid}, 32'h1);
    tick();
    check("t3_rd_valid_pulse", {31'b0, rd_valid}, 32'h0);
    check("t3_rd_val_hold", {31'b0, rd_val}, 32'h1);
    addr  = 5'd1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_rd_val_a1", {31'b0, rd_val}, 32'h0);
    check("t3_rd_valid_a1", {31'b0, rd_valid}, 32'h1);

    // Test 4: timeout with bit 7 toggling every cycle
    in_data = 32'hA5A5_0F0E;
    for (int i = 0; i < 4; i++) begin
      in_data = in_data ^ 32'h80;
      tick();
    end
    en_capture = 1'b1;
    in_data = in_data ^ 32'h80;
    tick();
    en_capture = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      in_data = in_data ^ 32'h80;
      tick();
      if (cap_timeout || cap_done) seen = 1'b1;
    end
    check("t4_no_early_event", {31'b0, seen}, 32'h0);
    in_data = in_data ^ 32'h80;
    tick();
    check("t4_timeout", {31'b0, cap_timeout}, 32'h1);
    check("t4_done", {31'b0, cap_done}, 32'h0);
    check("t4_busy", {31'b0, cap_busy}, 32'h0);
    check("t4_snap_kept", snap, 32'hA5A5_0F0E);
    check("t4_mask_kept", changed_mask, 32'h0000_0001);
    tick();
    check("t4_timeout_pulse", {31'b0, cap_timeout}, 32'h0);

    // Test 5: bit 3 changes early in WAIT, restarting the stability count
    in_data = 32'hA5A5_0F0E;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    tick();
    in_data = 32'hA5A5_0F06;
    tick();
    tick();
    tick();
    check("t5_no_commit_e4", {31'b0, cap_done}, 32'h0);
    seen = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      tick();
      if (cap_done) seen = 1'b1;
    end
    check("t5_no_commit_e5_7", {31'b0, seen}, 32'h0);
    tick();
    check("t5_done_e8", {31'b0, cap_done}, 32'h1);
    check("t5_snap", snap, 32'hA5A5_0F06);
    check("t5_mask", changed_mask, 32'h0000_0008);

    // Test 6: read and en_capture coincident with a commit
    in_data = 32'h0;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    repeat (4) tick();
    check("t6_pre_snap", snap, 32'h0);
    check("t6_pre_mask", changed_mask, 32'hA5A5_0F06);
    rd_sel = 1'b1;
    addr   = 5'd1;
    rd_en  = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t6_pre_rd_val", {31'b0, rd_val}, 32'h1);
    in_data = 32'h8000_0000;
    repeat (4) tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    tick();
    en_capture = 1'b1;
    tick();
    en_capture = 1'b0;
    check("t6_busy_ignored_req", {31'b0, cap_busy}, 32'h1);
    tick();
    en_capture = 1'b1;
    rd_en      = 1'b1;
    rd_sel     = 1'b0;
    addr       = 5'd31;
    tick();
    en_capture = 1'b0;
    rd_en      = 1'b0;
    check("t6_done", {31'b0, cap_done}, 32'h1);
    check("t6_snap", snap, 32'h8000_0000);
    check("t6_mask", changed_mask, 32'h8000_0000);
    check("t6_rd_val_old", {31'b0, rd_val}, 32'h0);
    check("t6_rd_valid", {31'b0, rd_valid}, 32'h1);
    check("t6_busy_after", {31'b0, cap_busy}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cap_done || cap_busy) seen = 1'b1;
    end
    check("t6_single_done", {31'b0, seen}, 32'h0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t6_rd_val_new", {31'b0, rd_val}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_input_sampler

// File: doc/input_sampler.md
Name: input_sampler

Overview:
- Capture side of the intercept path: synchronises the raw 32-bit intercepted input bus and takes a debounced snapshot on request.
- Exposes single-bit reads of the snapshot, or of the change mask, by 5-bit address.
- Feeds the bit-level decision logic that drives the output buffer's do_write/val controls.

Parameters:
- SYNC_STAGES, 2, number of flops in the per-bit synchroniser on in_data; legal range ≥2.
- STABLE_CYCLES, 4, consecutive unchanged synchronised cycles required before a snapshot commits; legal range ≥1.
- TIMEOUT, 64, maximum cycles in WAIT before the capture is abandoned; must be > STABLE_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  32  raw intercepted input bus, asynchronous to clk.
- en_capture  in  1  request a snapshot; ignored while busy.
- addr  in  5  bit index for reads.
- rd_en  in  1  read strobe.
- rd_sel  in  1  0 = read the snapshot, 1 = read the change mask.
- snap  out  32  last committed snapshot.
- changed_mask  out  32  XOR of the previous snapshot and the latest snapshot.
- rd_val  out  1  registered read data.
- rd_valid  out  1  read data valid, one-cycle pulse.
- cap_busy  out  1  high while in WAIT.
- cap_done  out  1  one-cycle pulse on snapshot commit.
- cap_timeout  out  1  one-cycle pulse on abandoned capture.

Behaviour:
- Reset (async):
  - All synchroniser flops, sync_prev, snap, changed_mask, rd_val, rd_valid, cap_done, cap_timeout, cnt and tmo clear to 0.
  - FSM goes to IDLE.
  - Asserting reset mid-WAIT abandons the capture with no pulse.
- Synchroniser:
  - in_data passes through SYNC_STAGES flops; the last stage is sync_data.
  - sync_prev is sync_data delayed one cycle.
  - Both run continuously, independent of the FSM.
- FSM states: IDLE, WAIT.
  - IDLE: cap_busy = 0. On en_capture = 1: go to WAIT, cnt <= 0, tmo <= 0.
  - WAIT: cap_busy = 1. Each clock:
    - cnt_next = (sync_data == sync_prev) ? cnt + 1 : 0
    - tmo_next = tmo + 1
  - Commit when cnt_next == STABLE_CYCLES:
    - changed_mask <= snap ^ sync_data
    - snap <= sync_data
    - cap_done pulses 1 cycle
    - go to IDLE
  - Otherwise, when tmo_next == TIMEOUT: cap_timeout pulses 1 cycle; snap and changed_mask are unchanged; go to IDLE.
  - Commit and timeout on the same edge: commit wins, and cap_timeout stays 0.
- Capture latency:
  - en_capture is sampled at edge E0.
  - For an input that is already stable and synchronised, snap, changed_mask and cap_done are visible after edge E0 + STABLE_CYCLES.
- Capture requests:
  - en_capture while busy is ignored, with no queuing.
  - en_capture in the same cycle as a commit or timeout is also ignored (FSM still in WAIT that cycle).
- Read:
  - rd_en at edge N gives rd_valid = 1 and rd_val valid after edge N.
  - rd_val = rd_sel ? changed_mask[addr] : snap[addr], using register values before edge N's update. A read coincident with a commit returns the old value.
  - rd_valid = 0 in cycles without rd_en; rd_val holds its last value.
  - Reads are legal in any FSM state.
- Width rules:
  - cnt is $clog2(STABLE_CYCLES+1) bits; tmo is $clog2(TIMEOUT+1) bits.
  - Neither counter wraps, because the FSM leaves WAIT at its terminal value.
  - addr covers all 32 bits, so there is no out-of-range case.

Decomposition:
- Shared package holds:
  - DATA_W = 32 and ADDR_W = 5, shared with the output buffer.
  - FSM state typedef (IDLE, WAIT).
- One natural sub-module, bus_synchronizer: a parameterised-width, SYNC_STAGES-deep flop chain with async reset.
- FSM, counters and read port stay in input_sampler.

Test Plan:
1. Reset mid-WAIT: hold in_data = 0xFFFF_FFFF, pulse en_capture, assert reset 2 cycles later -> all outputs 0, FSM IDLE; a following en_capture behaves normally.
2. Steady capture: in_data = 0xA5A5_0F0F held ≥3 cycles, en_capture at E0 -> snap = 0xA5A5_0F0F and cap_done = 1 after E0+4, changed_mask = 0xA5A5_0F0F, cap_busy 1 for exactly 4 cycles.
3. Change mask: follow test 2 with in_data = 0xA5A5_0F0E and a second capture -> changed_mask = 0x0000_0001; then rd_sel = 1, addr = 0, rd_en -> rd_val = 1, rd_valid pulses 1 cycle; addr = 1 -> rd_val = 0.
4. Timeout: toggle in_data[7] every cycle, en_capture at E0 -> cap_timeout pulses after E0+64, snap unchanged, cap_done never asserts.
5. Debounce restart: bit 3 glitches 2 cycles into WAIT, then holds -> commit is delayed so cap_done follows 4 stable synchronised cycles after the glitch, with the post-glitch value.
6. Coincident events: rd_en with rd_sel = 0, addr = 31 on the commit edge of 0x8000_0000 over old snap 0 -> rd_val = 0. en_capture during WAIT is ignored, giving exactly one cap_done.
